// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-wide data memory.
// Sub-word stores are built from a read-modify-write of the containing word.
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state, state_nxt;
  logic        we_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic        accept;
  logic        req_err;
  logic        out_range;
  logic        misaligned;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic        sgn,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = 16'(word >> {lane[1], 4'b0000});
    case (size)
      2'b00:   return sgn ? {{24{b[7]}}, b} : {24'd0, b};
      2'b01:   return sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] m;
    m = old;
    case (size)
      2'b00:   m[{lane, 3'b000} +: 8]     = wdata[7:0];
      2'b01:   m[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: m = wdata;
    endcase
    return m;
  endfunction

  assign out_range  = (req_addr >> (ADDR_W + 2)) != 32'd0;
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_err    = (req_size == 2'b11) || misaligned || out_range;

  assign req_ready  = (state == IDLE) && rst_n;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP) && rst_n;
  assign mem_we     = (state == WR) && rst_n;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                         state_nxt = RESP;
          else if (req_we && req_size == 2'b10) state_nxt = WR;
          else                                 state_nxt = RD;
        end
      end
      RD:      state_nxt = we_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q     <= req_we;
        size_q   <= req_size;
        sgn_q    <= req_signed;
        lane_q   <= req_addr[1:0];
        wdata_q  <= req_wdata;
        mem_addr <= req_addr[ADDR_W+1:2];
        if (!req_err && req_we && req_size == 2'b10) mem_din <= req_wdata;
      end
      // Partial stores merge the word read this cycle into the write data.
      if (state == RD && we_q) mem_din <= store_merge(mem_dout, wdata_q, size_q, lane_q);
      if (state_nxt == RESP) begin
        resp_err   <= (state == IDLE);
        resp_rdata <= (state == RD && !we_q) ? load_extract(mem_dout, size_q, sgn_q, lane_q)
                                             : 32'd0;
      end
    end
  end

endmodule
